// File: rtl/gray_updown_if.sv
// Control and status bundle for gray_updown: step/load/clear requests in,
// Gray and binary count plus wrap flags out.
interface gray_updown_if #(
  parameter int unsigned WIDTH = 3
);
  logic             Clr;
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] Bin;
  logic             Overflow;
  logic             Underflow;
  logic             Tc;

  modport master (
    output Clr, En, Up, Load, LoadVal,
    input  Output, Bin, Overflow, Underflow, Tc
  );

  modport slave (
    input  Clr, En, Up, Load, LoadVal,
    output Output, Bin, Overflow, Underflow, Tc
  );
endinterface

// File: rtl/gray_updown.sv
// Up/down Gray-code counter with sticky over/underflow and a terminal-count pulse.
// Define GRAY_UPDOWN_SAT_EN to saturate at the ends instead of wrapping.
module gray_updown #(
  parameter int unsigned WIDTH = 3
) (
  input  logic          Clk,
  input  logic          Reset_n,
  gray_updown_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] b_q, b_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_bin;

  // Gray-to-binary: each binary bit folds in every Gray bit above it.
  always_comb begin
    load_bin = '0;
    load_bin[WIDTH-1] = bus.LoadVal[WIDTH-1];
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      load_bin[i-1] = load_bin[i] ^ bus.LoadVal[i-1];
    end
  end

  always_comb begin
    b_d   = b_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    tc_d  = 1'b0;
    if (bus.Clr) begin
      b_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (bus.Load) begin
      b_d = load_bin;
    end else if (bus.En) begin
      if (bus.Up) begin
        if (b_q == MAX_VAL) begin
          ovf_d = 1'b1;
          tc_d  = 1'b1;
`ifdef GRAY_UPDOWN_SAT_EN
          b_d   = MAX_VAL;
`else
          b_d   = '0;
`endif
        end else begin
          b_d = b_q + ONE;
        end
      end else begin
        if (b_q == '0) begin
          unf_d = 1'b1;
          tc_d  = 1'b1;
`ifdef GRAY_UPDOWN_SAT_EN
          b_d   = '0;
`else
          b_d   = MAX_VAL;
`endif
        end else begin
          b_d = b_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      b_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      b_q   <= b_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.Bin       = b_q;
  assign bus.Output    = b_q ^ (b_q >> 1);
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
  assign bus.Tc        = tc_q;

endmodule

// File: doc/gray_updown.md
GRAY_UPDOWN -- requirements
Module: gray_updown

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the counter width in bits; the legal range is 2..16.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Clr, input, 1 bit: synchronous clear of count and flags.
REQ-005 The block SHALL have port En, input, 1 bit: step enable.
REQ-006 The block SHALL have port Up, input, 1 bit: direction; 1 = up, 0 = down; sampled only when En=1.
REQ-007 The block SHALL have port Load, input, 1 bit: synchronous load of LoadVal.
REQ-008 The block SHALL have port LoadVal, input, WIDTH bits: Gray-coded load value.
REQ-009 The block SHALL have port Output, output reg, WIDTH bits: current count, Gray-coded.
REQ-010 The block SHALL have port Bin, output, WIDTH bits: current count, binary.
REQ-011 The block SHALL have port Overflow, output reg, 1 bit: sticky up-wrap or up-saturation flag.
REQ-012 The block SHALL have port Underflow, output reg, 1 bit: sticky down-wrap or down-saturation flag.
REQ-013 The block SHALL have port Tc, output reg, 1 bit: one-cycle terminal-count pulse.

Function
REQ-014 The block SHALL hold the count as a WIDTH-bit binary register B, with Bin = B and Output = B ^ (B >> 1), both valid in the same cycle as B.
REQ-015 The block SHALL apply update priority per edge as Clr > Load > En; with none of these asserted, B and all flags hold and Tc = 0.
REQ-016 On Clr, the block SHALL set B = 0, Overflow = 0, Underflow = 0 and Tc = 0 on the next edge.
REQ-017 On Load (Clr = 0), the block SHALL set B = Gray-to-binary(LoadVal), with B[WIDTH-1] = LoadVal[WIDTH-1] and B[i] = B[i+1] ^ LoadVal[i]; Output then equals LoadVal next cycle, flags hold, and Tc = 0.
REQ-018 On En & Up with B < 2^WIDTH-1, the block SHALL set B = B+1, so Output changes in exactly one bit.
REQ-019 On En & !Up with B > 0, the block SHALL set B = B-1, so Output changes in exactly one bit.
REQ-020 On En & Up with B = 2^WIDTH-1 (terminal up), the block SHALL set Overflow = 1 and Tc = 1 for one cycle; B is updated per REQ-028 (configuration).
REQ-021 On En & !Up with B = 0 (terminal down), the block SHALL set Underflow = 1 and Tc = 1 for one cycle; B is updated per REQ-028 (configuration).
REQ-022 The block SHALL keep Overflow and Underflow sticky: once set, each is cleared only by Clr or Reset_n, and both may be 1 at once.
REQ-023 The block SHALL deassert Tc on every edge where no terminal event occurs, including a Load or Clr asserted in the same cycle as a would-be terminal step.
REQ-024 The block SHALL latch no state when Up changes while En = 0.

Reset
REQ-025 While Reset_n = 0, the block SHALL immediately force B = 0 (Output = 0, Bin = 0), Overflow = 0, Underflow = 0 and Tc = 0, independent of Clk.
REQ-026 A reset asserted mid-count or mid-Tc-pulse SHALL take effect at once; the first step after deassertion SHALL start from 0.
REQ-027 Deassertion of Reset_n SHALL be honoured on the first Clk edge at which Reset_n = 1; the block makes no other assumption about deassertion timing.

Configuration
REQ-028 The block SHALL support macro GRAY_UPDOWN_SAT_EN, which selects the terminal-step behaviour:
- Defined (saturate): a terminal up step holds B = 2^WIDTH-1, and a terminal down step holds B = 0.
- Undefined (wrap): a terminal up step sets B = 0, and a terminal down step sets B = 2^WIDTH-1.
- Flags and Tc behave identically in both builds.

Verification
REQ-029 The bench SHALL cover each of the following directed scenarios:
- WIDTH=3, wrap build, Reset_n pulse then En=1, Up=1 for 9 cycles -> Output 000,001,011,010,110,111,101,100,000; Tc=1 only on the 100->000 edge; Overflow=1 thereafter.
- WIDTH=3, from 0, En=1, Up=0 for 1 cycle -> Output 100 (wrap build) or 000 (sat build); Underflow=1 and Tc=1 in both builds.
- WIDTH=4, Load=1 with LoadVal=4'b1010 -> Output=1010 and Bin=1100 next cycle; then Load=1 and En=1 together -> load wins and no step occurs.
- WIDTH=3, at B=7 with Clr=1, En=1, Up=1 -> B=0, Tc=0, Overflow=0.
- WIDTH=8, Reset_n dropped asynchronously between edges at B=0x5A -> Output=0 before the next Clk edge; then 255 up-steps -> B=255, Overflow=0.
- All WIDTH in {2,3,8,16}, random En/Up/Load stimulus -> every En step changes exactly one Output bit, and Output always equals Bin ^ (Bin >> 1).
